hazard_ctrl: RTL and testbench

- Pipeline interlock and forwarding controller for the 5-stage CPU; sits beside the decode stage.
- Keeps its own scoreboard of in-flight destination registers in the EX, MEM and WB stages.
- From the scoreboard and the decoded control bits it generates load-use stalls, control-hazard flushes, EX-stage forwarding selects and the decode-stage register-file bypass.
- It is the sequencing authority for the IF/ID and ID/EX pipeline registers.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/fwd_sel.sv | 28 ++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: scoreboard entry, forward selects, register constants.
// Used by hazard_ctrl and fwd_sel.
package cpu_pkg;

    localparam int RA_W = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [RA_W-1:0] REG_ZERO = 5'd0;
    localparam logic [RA_W-1:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic            v;
        logic            regwr;
        logic            memrd;
        logic [RA_W-1:0] dst;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic            use_rs;
        logic            use_rt;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // True when entry e will write register r (r0 is never a hazard).
    function automatic logic haz(
        input logic [RA_W-1:0] r,
        input sb_entry_t       e
    );
        return e.v & e.regwr & (e.dst == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// EX operand forward select for one source register.
// Nearer stage (EX/MEM) wins over MEM/WB.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [RA_W-1:0] src,
    input  logic            use_src,
    input  sb_entry_t       mem_e,
    input  sb_entry_t       wb_e,
    output logic [1:0]      sel
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = use_src & haz(src, mem_e);
    assign hit_wb  = use_src & haz(src, wb_e);

    always_comb begin
        sel = FWD_REG;
        priority case (1'b1)
            hit_mem: sel = FWD_EXMEM;
            hit_wb:  sel = FWD_MEMWB;
            default: sel = FWD_REG;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock/forwarding controller with EX/MEM/WB destination scoreboard.
// Optional HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_regwr,
    input  logic [RA_W-1:0] id_dst,
    input  logic            id_memrd,
    input  logic            id_jump,
    input  logic            ex_redirect,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic            stall,
    output logic            flush_ifid,
    output logic            bubble_idex,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            byp_a,
    output logic            byp_b
);

    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;
    sb_entry_t wb_q, wb_d;

    logic       load_use;
    logic       stall_c;
    logic       bubble_c;
    logic       flush_c;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

    assign load_use = id_valid & ex_q.memrd &
                      ((id_use_rs & haz(id_rs, ex_q)) |
                       (id_use_rt & haz(id_rt, ex_q)));

    // A redirect squashes the wrong-path ID instruction instead of holding it.
    assign stall_c  = load_use & ~ex_redirect;
    assign bubble_c = stall_c | ex_redirect;
    assign flush_c  = ex_redirect | (id_jump & id_valid & ~stall_c);

    always_comb begin
        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = SB_EMPTY;
        if (id_valid && !bubble_c) begin
            ex_d.v      = 1'b1;
            ex_d.regwr  = id_regwr;
            ex_d.memrd  = id_memrd;
            ex_d.dst    = id_dst;
            ex_d.rs     = id_rs;
            ex_d.rt     = id_rt;
            ex_d.use_rs = id_use_rs;
            ex_d.use_rt = id_use_rt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    fwd_sel u_fwd_a (
        .src     (ex_q.rs),
        .use_src (ex_q.use_rs),
        .mem_e   (mem_q),
        .wb_e    (wb_q),
        .sel     (fwd_a_c)
    );

    fwd_sel u_fwd_b (
        .src     (ex_q.rt),
        .use_src (ex_q.use_rt),
        .mem_e   (mem_q),
        .wb_e    (wb_q),
        .sel     (fwd_b_c)
    );

    // Outputs are held low while reset is asserted, whatever ID presents.
    assign stall       = reset & stall_c;
    assign flush_ifid  = reset & flush_c;
    assign bubble_idex = reset & bubble_c;
    assign fwd_a       = reset ? fwd_a_c : FWD_REG;
    assign fwd_b       = reset ? fwd_b_c : FWD_REG;
    assign byp_a       = reset & id_valid & id_use_rs & haz(id_rs, wb_q);
    assign byp_b       = reset & id_valid & id_use_rt & haz(id_rt, wb_q);

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_c && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_c && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard cases plus random
// instruction streams checked against an instruction-history model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_use_rs, id_use_rt, id_regwr, id_memrd, id_jump;
    logic       ex_redirect;
    logic       stall, flush_ifid, bubble_idex, byp_a, byp_b;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
    int unsigned m_stall_cnt, m_flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_regwr    (id_regwr),
        .id_dst      (id_dst),
        .id_memrd    (id_memrd),
        .id_jump     (id_jump),
        .ex_redirect (ex_redirect),
`ifdef HAZARD_STATS_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .stall       (stall),
        .flush_ifid  (flush_ifid),
        .bubble_idex (bubble_idex),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .byp_a       (byp_a),
        .byp_b       (byp_b)
    );

    typedef struct {
        bit v, wr, ld, jmp, urs, urt;
        int dst, rs, rt;
    } ins_t;

    // hist[0] = instruction now in EX, hist[1] = MEM, hist[2] = WB.
    ins_t hist[3];
    ins_t nop_i;
    logic [8:0] expq[$];
    int n_checks = 0;
    int n_err = 0;
    bit last_stall = 0;

    function automatic bit writes(ins_t e, int r);
        return e.v && e.wr && e.dst == r && r != 0;
    endfunction

    // Age (1 = one stage ahead of EX) of the newest producer of r, 0 if none.
    function automatic int producer_age(int r);
        for (int k = 1; k <= 2; k++)
            if (writes(hist[k], r)) return k;
        return 0;
    endfunction

    function automatic logic [8:0] model(ins_t id, bit redir);
        bit lu, st, fl, bu, ba, bb;
        int aa, ab;
        lu = id.v && hist[0].ld &&
             ((id.urs && writes(hist[0], id.rs)) ||
              (id.urt && writes(hist[0], id.rt)));
        st = lu && !redir;
        bu = st || redir;
        fl = redir || (id.jmp && id.v && !st);
        aa = hist[0].v && hist[0].urs ? producer_age(hist[0].rs) : 0;
        ab = hist[0].v && hist[0].urt ? producer_age(hist[0].rt) : 0;
        ba = id.v && id.urs && writes(hist[2], id.rs);
        bb = id.v && id.urt && writes(hist[2], id.rt);
        return {st, fl, bu, 2'(aa), 2'(ab), ba, bb};
    endfunction

    function automatic ins_t mk(bit v, int dst, int rs, int rt,
                                bit urs, bit urt, bit wr, bit ld, bit jmp);
        ins_t i;
        i.v = v; i.dst = dst; i.rs = rs; i.rt = rt;
        i.urs = urs; i.urt = urt; i.wr = wr; i.ld = ld; i.jmp = jmp;
        return i;
    endfunction

    task automatic drive(ins_t i, bit redir);
        id_valid = i.v; id_rs = 5'(i.rs); id_rt = 5'(i.rt);
        id_dst = 5'(i.dst); id_use_rs = i.urs; id_use_rt = i.urt;
        id_regwr = i.wr; id_memrd = i.ld; id_jump = i.jmp;
        ex_redirect = redir;
    endtask

    // One clock of stimulus: expected outputs go to the queue, then the
    // history advances across the edge.
    task automatic step(ins_t i, bit redir);
        logic [8:0] e;
        drive(i, redir);
        e = model(i, redir);
        expq.push_back(e);
        @(posedge clk);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = (e[6] || !i.v) ? nop_i : i;
        last_stall = e[8];
`ifdef HAZARD_STATS_EN
        if (e[8]) m_stall_cnt++;
        if (e[7]) m_flush_cnt++;
`endif
        #1;
    endtask

    function automatic logic [8:0] outs();
        return {stall, flush_ifid, bubble_idex, fwd_a, fwd_b, byp_a, byp_b};
    endfunction

    task automatic check_zero(string tag);
        n_checks++;
        if (outs() !== 9'd0) begin
            n_err++;
            $display("FAIL %s: outputs got %b expected 000000000", tag, outs());
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) hist[k] = nop_i;
`ifdef HAZARD_STATS_EN
        m_stall_cnt = 0;
        m_flush_cnt = 0;
`endif
    endtask

    // Monitor: pops the expectation for this cycle and compares mid-cycle.
    always @(negedge clk) begin
        logic [8:0] e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            n_checks++;
            if (outs() !== e) begin
                n_err++;
                $display("FAIL outs t=%0t: {stall,flush,bubble,fa,fb,ba,bb} got %b expected %b",
                         $time, outs(), e);
            end
`ifdef HAZARD_STATS_EN
            n_checks++;
            if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
                n_err++;
                $display("FAIL counters: got %0d/%0d expected %0d/%0d",
                         stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
            end
`endif
        end
    end

    initial begin
        ins_t lw8, add9, add3, sub4, indep, lw0, add5, beq, jal, jr31, r;
        logic [8:0] e;
        bit redir;
        nop_i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        clear_model();
        reset = 1'b0;
        drive(mk(1, 7, 1, 2, 1, 1, 1, 0, 1), 1'b1);
        #12;
        check_zero("reset_hold");
        drive(nop_i, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_zero("after_reset");

        lw8   = mk(1, 8, 1, 0, 1, 0, 1, 1, 0);
        add9  = mk(1, 9, 8, 2, 1, 1, 1, 0, 0);
        add3  = mk(1, 3, 1, 2, 1, 1, 1, 0, 0);
        sub4  = mk(1, 4, 3, 3, 1, 1, 1, 0, 0);
        indep = mk(1, 6, 1, 2, 1, 1, 1, 0, 0);
        lw0   = mk(1, 0, 1, 0, 1, 0, 1, 1, 0);
        add5  = mk(1, 5, 0, 0, 1, 1, 1, 0, 0);
        beq   = mk(1, 0, 1, 2, 1, 1, 0, 0, 0);
        jal   = mk(1, 31, 0, 0, 0, 0, 1, 0, 1);
        jr31  = mk(1, 0, 31, 0, 1, 0, 0, 0, 0);

        // load-use: one stall, then MEM/WB forward
        step(lw8, 0); step(add9, 0); step(add9, 0);
        step(nop_i, 0); step(nop_i, 0); step(nop_i, 0);
        // back-to-back ALU, then one independent between
        step(add3, 0); step(sub4, 0); step(nop_i, 0);
        step(add3, 0); step(indep, 0); step(sub4, 0); step(nop_i, 0);
        step(nop_i, 0); step(nop_i, 0);
        // zero register
        step(lw0, 0); step(add5, 0); step(nop_i, 0);
        step(nop_i, 0); step(nop_i, 0);
        // taken branch in EX while ID has a load-use hazard
        step(lw8, 0); step(add9, 1); step(nop_i, 0);
        step(nop_i, 0); step(nop_i, 0);
        // jal then jr $31 two slots later
        step(jal, 0); step(nop_i, 0); step(jr31, 0); step(nop_i, 0);
        step(nop_i, 0); step(nop_i, 0);
        // jump held behind a load-use stall
        step(lw8, 0);
        step(mk(1, 31, 8, 0, 1, 0, 1, 0, 1), 0);
        step(mk(1, 31, 8, 0, 1, 0, 1, 0, 1), 0);
        step(nop_i, 0); step(nop_i, 0); step(nop_i, 0);

        // reset asserted mid-stream while stall is high
        step(lw8, 0);
        drive(add9, 0);
        e = model(add9, 0);
        expq.push_back(e);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        clear_model();
        @(posedge clk);
        #1;
        check_zero("mid_reset_edge");
        @(negedge clk);
        drive(nop_i, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(add9, 0); step(add9, 0); step(nop_i, 0);

        // random streams over a small register set to provoke hazards
        r = nop_i;
        for (int n = 0; n < 600; n++) begin
            redir = ($urandom_range(0, 7) == 0);
            if (!last_stall) begin
                r.v   = ($urandom_range(0, 5) != 0);
                r.rs  = $urandom_range(0, 4);
                r.rt  = $urandom_range(0, 4);
                if (r.rs == 4) r.rs = 31;
                r.dst = $urandom_range(0, 3);
                r.urs = $urandom_range(0, 1);
                r.urt = $urandom_range(0, 1);
                r.wr  = ($urandom_range(0, 3) != 0);
                r.ld  = ($urandom_range(0, 2) == 0);
                r.jmp = ($urandom_range(0, 9) == 0);
                if (r.jmp) begin r.ld = 0; r.dst = 31; end
            end
            step(r, redir);
        end
        step(nop_i, 0);
        @(negedge clk);
        #1;
        n_checks++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL drain: queue got %0d expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
